// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the multi-channel PWM core
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// rtl/pwm_channel_cmp.sv - registered duty compare and polarity stage for one PWM channel
module pwm_channel_cmp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             pol,
  output logic             pwm
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else if (en) begin
      pwm <= pol ^ (cnt < duty);
    end else begin
      pwm <= pol;
    end
  end

endmodule

// File: rtl/pwm_multi_core.sv
// rtl/pwm_multi_core.sv - shared timebase with shadowed period/duty/mode and NCH compare channels
module pwm_multi_core
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   period_i,
  input  logic [NCH*WIDTH-1:0] duty_i,
  input  logic [NCH-1:0]     pol_i,
  input  logic               load_i,
  output logic [NCH-1:0]     pwm_o,
  output logic               period_end_o,
  output logic               upd_ack_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     cnt;
  dir_t                 dir;
  logic                 mode_act, mode_pend, pend_valid;
  logic [WIDTH-1:0]     period_act, period_pend;
  logic [NCH*WIDTH-1:0] duty_act, duty_pend;
  logic                 boundary;

  // Center mode with P == 1 reaches cnt == 1 still counting up, so it is a boundary too.
  always_comb begin
    boundary = 1'b0;
    if (period_act == '0) begin
      boundary = 1'b1;
    end else if (mode_act == MODE_EDGE) begin
      boundary = (cnt == period_act);
    end else begin
      boundary = (cnt == ONE) && ((dir == DIR_DOWN) || (period_act == ONE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_act     <= MODE_EDGE;
      mode_pend    <= MODE_EDGE;
      period_act   <= '0;
      period_pend  <= '0;
      duty_act     <= '0;
      duty_pend    <= '0;
      pend_valid   <= 1'b0;
      period_end_o <= 1'b0;
      upd_ack_o    <= 1'b0;
    end else begin
      upd_ack_o    <= 1'b0;
      period_end_o <= 1'b0;
      if (!en) begin
        cnt <= '0;
        dir <= DIR_UP;
        if (load_i) begin
          mode_act   <= mode_i;
          period_act <= period_i;
          duty_act   <= duty_i;
          pend_valid <= 1'b0;
          upd_ack_o  <= 1'b1;
        end
      end else begin
        period_end_o <= boundary;
        if (boundary) begin
          cnt <= '0;
          dir <= DIR_UP;
          // A load landing on the boundary itself skips the pending stage.
          if (load_i) begin
            mode_act   <= mode_i;
            period_act <= period_i;
            duty_act   <= duty_i;
            pend_valid <= 1'b0;
            upd_ack_o  <= 1'b1;
          end else if (pend_valid) begin
            mode_act   <= mode_pend;
            period_act <= period_pend;
            duty_act   <= duty_pend;
            pend_valid <= 1'b0;
            upd_ack_o  <= 1'b1;
          end
        end else begin
          if (load_i) begin
            mode_pend   <= mode_i;
            period_pend <= period_i;
            duty_pend   <= duty_i;
            pend_valid  <= 1'b1;
          end
          if (mode_act == MODE_EDGE) begin
            cnt <= cnt + ONE;
          end else if (dir == DIR_UP) begin
            if (cnt == period_act) begin
              dir <= DIR_DOWN;
              cnt <= cnt - ONE;
            end else begin
              cnt <= cnt + ONE;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .cnt  (cnt),
      .duty (duty_act[i*WIDTH +: WIDTH]),
      .pol  (pol_i[i]),
      .pwm  (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_core.sv
// tb/tb_pwm_multi_core.sv - scoreboard bench for pwm_multi_core
module tb_pwm_multi_core;
  import pwm_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, en, mode_i, load_i;
  logic [W-1:0]   period_i;
  logic [N*W-1:0] duty_i;
  logic [N-1:0]   pol_i;
  logic [N-1:0]   pwm_o;
  logic           period_end_o, upd_ack_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] sb[$];
  logic [5:0] obs, exp_v;

  pwm_multi_core #(.WIDTH(W), .NCH(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode_i       (mode_i),
    .period_i     (period_i),
    .duty_i       (duty_i),
    .pol_i        (pol_i),
    .load_i       (load_i),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o),
    .upd_ack_o    (upd_ack_o)
  );

  always #5 clk = ~clk;

  // Expected {ack, period_end, pwm} for the k-th enabled cycle, from the closed-form counter position.
  function automatic logic [5:0] model(input logic m, input logic [15:0] p, input logic [63:0] d,
                                       input logic [3:0] pl, input int k, input logic ack);
    int len, j, c;
    logic [5:0] r;
    if (p == 16'd0) begin
      len = 1; j = 0; c = 0;
    end else begin
      len = m ? 2 * int'(p) : int'(p) + 1;
      j   = k % len;
      c   = (m && j > int'(p)) ? 2 * int'(p) - j : j;
    end
    for (int i = 0; i < 4; i++) r[i] = pl[i] ^ (c < int'(d[i*16 +: 16]));
    r[4] = (j == len - 1);
    r[5] = ack;
    return r;
  endfunction

  task automatic push_run(input logic m, input logic [15:0] p, input logic [63:0] d,
                          input logic [3:0] pl, input int n, input int ack_k);
    for (int k = 0; k < n; k++) sb.push_back(model(m, p, d, pl, k, k == ack_k));
  endtask

  task automatic configure(input logic m, input logic [15:0] p, input logic [63:0] d, input logic [3:0] pl);
    en = 1'b0; mode_i = m; period_i = p; duty_i = d; pol_i = pl; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load_i = 1'b0; mode_i = MODE_EDGE;
    period_i = '0; duty_i = '0; pol_i = 4'hF;
    @(negedge clk); @(negedge clk);
    obs = {upd_ack_o, period_end_o, pwm_o}; n_checks++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_hold got %b exp %b", obs, 6'b0); end
    rst = 1'b0;
    @(negedge clk);
    obs = {upd_ack_o, period_end_o, pwm_o}; n_checks++;
    if (obs !== 6'b00_1111) begin n_fail++; $display("FAIL reset_release got %b exp %b", obs, 6'b00_1111); end
    pol_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_wave(input string name, input logic m, input logic [15:0] p,
                           input logic [63:0] d, input logic [3:0] pl, input int n);
    configure(m, p, d, pl);
    en = 1'b1;
    push_run(m, p, d, pl, n, -1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL %s k=%0d got %b exp %b", name, k, obs, exp_v); end
    end
    en = 1'b0;
  endtask

  task automatic test_enable();
    configure(MODE_EDGE, 16'd4, {16'd1, 16'd2, 16'd3, 16'd4}, 4'b0110);
    obs = {upd_ack_o, period_end_o, pwm_o}; n_checks++;
    if (obs !== 6'b10_0110) begin n_fail++; $display("FAIL en_low_load got %b exp %b", obs, 6'b10_0110); end
    pol_i = 4'b1001;
    @(negedge clk);
    obs = {upd_ack_o, period_end_o, pwm_o}; n_checks++;
    if (obs !== 6'b00_1001) begin n_fail++; $display("FAIL en_low_pol got %b exp %b", obs, 6'b00_1001); end
    en = 1'b1;
    push_run(MODE_EDGE, 16'd4, {16'd1, 16'd2, 16'd3, 16'd4}, 4'b1001, 5, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL en_rise k=%0d got %b exp %b", k, obs, exp_v); end
    end
    en = 1'b0;
  endtask

  task automatic test_shadow();
    logic [63:0] d_old, d_new;
    d_old = {16'd4, 16'd2, 16'd0, 16'd3};
    d_new = {16'd0, 16'd5, 16'd2, 16'd1};
    configure(MODE_EDGE, 16'd9, d_old, 4'h0);
    en = 1'b1;
    push_run(MODE_EDGE, 16'd9, d_old, 4'h0, 10, 9);
    push_run(MODE_EDGE, 16'd4, d_new, 4'h0, 10, -1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL shadow k=%0d got %b exp %b", k, obs, exp_v); end
      if (k == 4) begin
        mode_i = MODE_CENTER; period_i = 16'd7; duty_i = {16'd1, 16'd1, 16'd1, 16'd6}; load_i = 1'b1;
      end
      if (k == 6) begin
        mode_i = MODE_EDGE; period_i = 16'd4; duty_i = d_new; load_i = 1'b1;
      end
      if (k == 5 || k == 7) load_i = 1'b0;
    end
    en = 1'b0;
  endtask

  task automatic test_boundary_load();
    logic [63:0] d_old, d_new;
    d_old = {16'd0, 16'd3, 16'd2, 16'd1};
    d_new = {16'd0, 16'd5, 16'd1, 16'd2};
    configure(MODE_CENTER, 16'd2, d_old, 4'h0);
    en = 1'b1;
    push_run(MODE_CENTER, 16'd2, d_old, 4'h0, 4, 3);
    push_run(MODE_EDGE, 16'd4, d_new, 4'h0, 6, -1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bnd_load k=%0d got %b exp %b", k, obs, exp_v); end
      if (k == 2) begin
        mode_i = MODE_EDGE; period_i = 16'd4; duty_i = d_new; load_i = 1'b1;
      end
      if (k == 3) load_i = 1'b0;
    end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    configure(MODE_EDGE, 16'd9, {4{16'd5}}, 4'h0);
    en = 1'b1;
    push_run(MODE_EDGE, 16'd9, {4{16'd5}}, 4'h0, 4, -1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_pre k=%0d got %b exp %b", k, obs, exp_v); end
      if (k == 1) begin
        period_i = 16'd2; duty_i = {4{16'd1}}; load_i = 1'b1;
      end
      if (k == 2) load_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    obs = {upd_ack_o, period_end_o, pwm_o}; n_checks++;
    if (obs !== 6'b0) begin n_fail++; $display("FAIL rst_async got %b exp %b", obs, 6'b0); end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    push_run(MODE_EDGE, 16'd0, 64'd0, 4'h0, 5, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {upd_ack_o, period_end_o, pwm_o}; exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_post k=%0d got %b exp %b", k, obs, exp_v); end
    end
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wave("edge_p4",    MODE_EDGE,   16'd4, {16'd3, 16'd5, 16'd0, 16'd2}, 4'b0000, 10);
    test_wave("center_p4",  MODE_CENTER, 16'd4, {16'd1, 16'd5, 16'd0, 16'd2}, 4'b0000, 16);
    test_wave("pol_center", MODE_CENTER, 16'd4, {16'd1, 16'd5, 16'd0, 16'd2}, 4'b0101, 8);
    test_wave("pol_edge",   MODE_EDGE,   16'd4, {16'd3, 16'd5, 16'd0, 16'd2}, 4'b1010, 5);
    test_wave("nch_duties", MODE_EDGE,   16'd4, {16'd5, 16'd3, 16'd1, 16'd0}, 4'b0000, 10);
    test_wave("p0_edge",    MODE_EDGE,   16'd0, {16'd1, 16'd0, 16'd1, 16'd1}, 4'b0000, 4);
    test_wave("p0_center",  MODE_CENTER, 16'd0, {16'd1, 16'd0, 16'd1, 16'd1}, 4'b0000, 4);
    test_wave("p1_center",  MODE_CENTER, 16'd1, {16'd1, 16'd2, 16'd0, 16'd1}, 4'b0000, 6);
    test_enable();
    test_shadow();
    test_boundary_load();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_core.md
Name: pwm_multi_core

Overview:
- Parametrised multi-channel PWM generator: one shared timebase counter, NCH independent duty compare channels.
- Supports edge-aligned and center-aligned counting, per-channel polarity, and shadowed (glitch-free) period/duty/mode updates applied only at period boundaries.
- Sits behind the Wishbone register block; clk comes from the clock-select/divider stage.

Parameters:
- WIDTH, 16, bit width of counter, period and each duty value.
- NCH, 4, number of PWM output channels (1..16).

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  core enable; low holds counter at 0 and outputs at inactive level.
- mode_i  input  1  0 = edge-aligned, 1 = center-aligned (shadowed).
- period_i  input  WIDTH  requested period value P (shadowed).
- duty_i  input  NCH*WIDTH  flat requested duty values D; channel i = bits [i*WIDTH +: WIDTH] (shadowed).
- pol_i  input  NCH  per-channel polarity, 1 = inverted; not shadowed.
- load_i  input  1  one-cycle strobe capturing mode_i/period_i/duty_i into pending registers.
- pwm_o  output  NCH  registered PWM outputs.
- period_end_o  output  1  one-cycle pulse in the cycle the counter wraps to 0.
- upd_ack_o  output  1  one-cycle pulse when pending values become active.

Behaviour:
- Reset:
  - cnt = 0, dir = up.
  - Active and pending registers = 0; pend_valid = 0.
  - pwm_o, period_end_o and upd_ack_o all = 0.
- Edge mode:
  - cnt runs 0,1,...,P,0,...; period length P+1 cycles.
  - Boundary when cnt == P_act.
- Center mode:
  - cnt runs 0 up to P, then P-1 down to 1, then 0; period length 2P cycles.
  - dir flips to down at cnt == P, and back to up at 0.
  - Boundary when dir == down and cnt == 1.
  - P == 1 gives the sequence 0,1,0,1; boundary at cnt == 1.
- P_act == 0, either mode: cnt stays 0; every enabled cycle is a boundary.
- Compare:
  - Registered: pwm_o[i] <= pol_i[i] XOR (cnt < D_act[i]).
  - Output lags counter by exactly 1 cycle.
  - Comparison is unsigned, WIDTH bits.
  - D == 0 gives constant inactive level.
  - Edge mode: D > P gives constant active level (100%).
  - Center mode: D > P gives constant active level (100%).
- period_end_o: registered, asserted the cycle after a boundary cycle, aligned with pwm_o.
- Shadowing:
  - load_i captures inputs into pending registers and sets pend_valid.
  - A later load before the boundary overwrites pending; last value wins.
  - At a boundary with pend_valid = 1: active <= pending, pend_valid <= 0, upd_ack_o pulses next cycle.
  - New values govern the first cycle of the next period (cnt == 0).
  - load_i coincident with a boundary: the new input values are applied at that same boundary (bypass pending).
- Mode change at a boundary restarts the count at cnt = 0, dir = up.
- en low:
  - cnt = 0, dir = up.
  - pwm_o[i] <= pol_i[i]; no period_end_o.
  - load_i copies directly into active registers and pulses upd_ack_o.
- en rising: first enabled cycle has cnt = 0; first pwm_o update follows one cycle later.
- rst asserted mid-period: immediate return to reset values; pending updates discarded.
- pol_i change: takes effect on the next registered output update, unshadowed.

Decomposition:
- Package pwm_pkg: MODE_EDGE = 1'b0, MODE_CENTER = 1'b1; default WIDTH/NCH constants.
- Sub-module pwm_channel_cmp:
  - One registered compare + polarity stage per channel.
  - Parameter WIDTH; inputs cnt, duty, pol, en.
  - Instantiated NCH times via generate.
- Timebase counter and shadow logic stay in the top module.

Test Plan:
- Edge, P=4, D0=2, pol=0: pwm_o[0] repeats 1,1,0,0,0; period_end_o pulses every 5 cycles.
- Center, P=4, D0=2: cnt runs 0,1,2,3,4,3,2,1; pwm_o[0] repeats 1,1,0,0,0,0,0,1; period_end_o every 8 cycles.
- Shadow update, edge P=9, D0=3:
  - Stimulus: load P=4, D0=1 at cnt=5.
  - Required: old waveform completes through cnt=9; upd_ack_o pulses; next period is 1,0,0,0,0.
  - A second load before the boundary: its values win.
- Boundary cases:
  - D=0 gives constant 0.
  - D=5 with P=4 gives constant 1 in both modes.
  - P=0, D=1 gives constant 1 with period_end_o every cycle.
  - pol=1 inverts each waveform.
- Enable/reset:
  - en low gives pwm_o = pol_i; load while disabled applies immediately.
  - rst pulse mid-period, with a pending load, clears all outputs and registers; the pending load is lost.
- NCH=4: four different duties 0, 1, 3, 5 at P=4 produce independent correct waveforms simultaneously.
